// File: rtl/apb_master_arb_if.sv
// Bundle between the two local requesters, the arbitrating APB master and the
// single APB slave. The master modport is the arbiter's view; the slave
// modport is the environment's view (requesters plus APB slave).
interface apb_master_arb_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // requester 0
   logic              req0;
   logic              write0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] rdata0;
   logic              done0;
   logic              err0;
   // requester 1
   logic              req1;
   logic              write1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic [DATA_W-1:0] rdata1;
   logic              done1;
   logic              err1;
   // APB side
   logic              select;
   logic              enable;
   logic [ADDR_W-1:0] ADDR;
   logic              WRITE;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] RDATA;
   logic              ready_i;
   // status
   logic              busy_o;
   logic              gnt_o;

   modport master (
      input  req0, write0, addr0, wdata0,
      input  req1, write1, addr1, wdata1,
      input  RDATA, ready_i,
      output rdata0, done0, err0,
      output rdata1, done1, err1,
      output select, enable, ADDR, WRITE, WDATA,
      output busy_o, gnt_o
   );

   modport slave (
      output req0, write0, addr0, wdata0,
      output req1, write1, addr1, wdata1,
      output RDATA, ready_i,
      input  rdata0, done0, err0,
      input  rdata1, done1, err1,
      input  select, enable, ADDR, WRITE, WDATA,
      input  busy_o, gnt_o
   );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// registered done/err pulses, read data capture and an optional ACCESS timeout.
module apb_master_arb #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic              clk,
   input logic              reset,
   apb_master_arb_if.master bus
);

   // Counter only ever needs to reach TIMEOUT-1; with TIMEOUT=0 it just wraps.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              eff0, eff1, win;

   // Next-state, arbitration and completion logic.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      wait_d   = wait_q;
      // A requester is masked while its done pulse is showing so a held req
      // cannot be granted twice for one command.
      eff0     = bus.req0 & ~done0_q;
      eff1     = bus.req1 & ~done1_q;
      win      = (eff0 & eff1) ? ~last_q : eff1;

      case (state_q)
         IDLE: begin
            if (eff0 | eff1) begin
               state_d = SETUP;
               last_d  = win;
               gnt_d   = win;
               write_d = win ? bus.write1 : bus.write0;
               addr_d  = win ? bus.addr1  : bus.addr0;
               wdata_d = win ? bus.wdata1 : bus.wdata0;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (bus.ready_i) begin
               state_d = IDLE;
               wait_d  = '0;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               if (!write_q) begin
                  if (gnt_q) rdata1_d = bus.RDATA;
                  else       rdata0_d = bus.RDATA;
               end
            end else if ((TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1))) begin
               state_d = IDLE;
               wait_d  = '0;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               err0_d  = ~gnt_q;
               err1_d  = gnt_q;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and favours requester 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         gnt_q    <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         wait_q   <= wait_d;
      end
   end

   assign bus.select = (state_q != IDLE);
   assign bus.enable = (state_q == ACCESS);
   assign bus.busy_o = (state_q != IDLE);
   assign bus.ADDR   = addr_q;
   assign bus.WRITE  = write_q;
   assign bus.WDATA  = wdata_q;
   assign bus.gnt_o  = gnt_q;
   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;
   assign bus.done0  = done0_q;
   assign bus.done1  = done1_q;
   assign bus.err0   = err0_q;
   assign bus.err1   = err1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios followed by random traffic,
// compared every cycle against a transaction-timeline reference model.
module tb_apb_master_arb;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   apb_master_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // A command carries the slave's behaviour for it: wait states and read data.
   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                w;
      logic [DATA_W-1:0] rd;
   } cmd_t;

   int   nerr = 0;
   int   nchk = 0;
   int   cyc  = 0;
   cmd_t q0[$];
   cmd_t q1[$];
   cmd_t cur[2];
   bit   hold[2];
   bit   granted[2];
   bit   d_req[2];
   int   glog[$];

   // Current / most recent transfer as a timeline: SETUP at t_setup,
   // ACCESS from t_setup+1 up to t_done-1, done pulse at t_done.
   bit                t_valid;
   int                t_setup, t_done, t_w;
   bit                t_err, t_win, t_wr;
   logic [ADDR_W-1:0] t_addr;
   logic [DATA_W-1:0] t_wdata, t_rd;
   bit                last;
   logic [DATA_W-1:0] exp_rd[2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic cmd_t mk(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] wd, input int w,
                               input logic [DATA_W-1:0] rd);
      cmd_t c;
      c.wr = wr; c.addr = a; c.wdata = wd; c.w = w; c.rd = rd;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      int sel;
      int w;
      sel = int'($urandom % 12);
      if (sel == 0)      w = TIMEOUT - 1;
      else if (sel == 1) w = TIMEOUT;
      else if (sel == 2) w = TIMEOUT + 5;
      else               w = int'($urandom % 4);
      return mk(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), w, DATA_W'($urandom));
   endfunction

   task automatic model_reset();
      t_valid = 1'b0; t_setup = 0; t_done = 0; t_w = 0;
      t_err = 1'b0; t_win = 1'b0; t_wr = 1'b0;
      t_addr = '0; t_wdata = '0; t_rd = '0;
      last = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      granted[0] = 1'b0; granted[1] = 1'b0;
   endtask

   task automatic check_cycle();
      bit act, en, dn0, dn1;
      if (t_valid && cyc == t_done && !t_err && !t_wr) exp_rd[t_win] = t_rd;
      act = t_valid && cyc >= t_setup && cyc < t_done;
      en  = act && cyc > t_setup;
      dn0 = t_valid && cyc == t_done && !t_win;
      dn1 = t_valid && cyc == t_done && t_win;
      check_eq("select", 64'(bus.select), 64'(act));
      check_eq("enable", 64'(bus.enable), 64'(en));
      check_eq("busy",   64'(bus.busy_o), 64'(act));
      check_eq("ADDR",   64'(bus.ADDR),   64'(t_addr));
      check_eq("WRITE",  64'(bus.WRITE),  64'(t_wr));
      check_eq("WDATA",  64'(bus.WDATA),  64'(t_wdata));
      check_eq("gnt",    64'(bus.gnt_o),  64'(t_win));
      check_eq("done0",  64'(bus.done0),  64'(dn0));
      check_eq("done1",  64'(bus.done1),  64'(dn1));
      check_eq("err0",   64'(bus.err0),   64'(dn0 && t_err));
      check_eq("err1",   64'(bus.err1),   64'(dn1 && t_err));
      check_eq("rdata0", 64'(bus.rdata0), 64'(exp_rd[0]));
      check_eq("rdata1", 64'(bus.rdata1), 64'(exp_rd[1]));
   endtask

   task automatic drive_sched();
      bit e0, e1, idle, in_acc, win;
      bit rdy;
      // retire the finished command, then fetch the next one
      if (t_valid && cyc == t_done) begin
         hold[t_win]    = 1'b0;
         granted[t_win] = 1'b0;
      end
      if (!hold[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); hold[0] = 1'b1; granted[0] = 1'b0; end
      if (!hold[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); hold[1] = 1'b1; granted[1] = 1'b0; end
      // requesters: hold the command until done, may drop/scramble once granted
      for (int n = 0; n < 2; n++) begin
         logic r, wr;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] wd;
         if (hold[n] && !(granted[n] && cyc >= t_setup && ($urandom % 4 == 0))) begin
            r = 1'b1; wr = cur[n].wr; a = cur[n].addr; wd = cur[n].wdata;
         end else begin
            r = 1'b0; wr = 1'($urandom); a = ADDR_W'($urandom); wd = DATA_W'($urandom);
         end
         d_req[n] = r;
         if (n == 0) begin bus.req0 = r; bus.write0 = wr; bus.addr0 = a; bus.wdata0 = wd; end
         else        begin bus.req1 = r; bus.write1 = wr; bus.addr1 = a; bus.wdata1 = wd; end
      end
      // slave: ready only on the chosen ACCESS cycle, noise elsewhere
      in_acc = t_valid && cyc > t_setup && cyc < t_done;
      if (in_acc) rdy = !t_err && (cyc == t_setup + 1 + t_w);
      else        rdy = 1'($urandom);
      bus.ready_i = rdy;
      bus.RDATA   = (in_acc && rdy) ? t_rd : DATA_W'($urandom);
      // arbitration decision for the next edge
      idle = !(t_valid && cyc >= t_setup && cyc < t_done);
      e0   = d_req[0] && !(t_valid && cyc == t_done && !t_win);
      e1   = d_req[1] && !(t_valid && cyc == t_done && t_win);
      if (idle && (e0 || e1)) begin
         win     = (e0 && e1) ? !last : e1;
         t_valid = 1'b1;
         t_win   = win;
         t_wr    = cur[win].wr;
         t_addr  = cur[win].addr;
         t_wdata = cur[win].wdata;
         t_rd    = cur[win].rd;
         t_w     = cur[win].w;
         t_err   = (TIMEOUT != 0) && (t_w >= TIMEOUT);
         t_setup = cyc + 1;
         t_done  = t_setup + 1 + (t_err ? TIMEOUT : t_w + 1);
         last    = win;
         granted[win] = 1'b1;
         glog.push_back(int'(win));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
      if (reset) drive_sched();
   endtask

   function automatic bit idle_now();
      return q0.size() == 0 && q1.size() == 0 && !hold[0] && !hold[1] &&
             !(t_valid && cyc < t_done);
   endfunction

   task automatic run_until_idle(input int max);
      int n = 0;
      while (!idle_now() && n < max) begin
         tick();
         n++;
      end
      check_eq("drain_in_budget", 64'(idle_now()), 64'd1);
   endtask

   initial begin
      reset = 1'b0;
      bus.req0 = 1'b0; bus.write0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.write1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      bus.RDATA = '0; bus.ready_i = 1'b0;
      hold[0] = 1'b0; hold[1] = 1'b0;
      model_reset();
      repeat (3) tick();
      reset = 1'b1;
      drive_sched();

      // single zero-wait write from requester 0
      q0.push_back(mk(1'b1, 10'h012, 32'hDEADBEEF, 0, 32'h0));
      run_until_idle(50);

      // read with two wait states from requester 1
      q1.push_back(mk(1'b0, 10'h3FF, 32'h0, 2, 32'hA5A5_0001));
      run_until_idle(50);

      // contention: both requesters hold two commands each
      glog.delete();
      q0.push_back(mk(1'b1, 10'h100, 32'h0000_0A00, 0, 32'h0));
      q0.push_back(mk(1'b0, 10'h101, 32'h0, 1, 32'h0000_0A01));
      q1.push_back(mk(1'b0, 10'h200, 32'h0, 0, 32'h0000_0B00));
      q1.push_back(mk(1'b1, 10'h201, 32'h0000_0B01, 2, 32'h0));
      run_until_idle(100);
      check_eq("grant_count", 64'(glog.size()), 64'd4);
      for (int i = 0; i < glog.size(); i++)
         check_eq("grant_order", 64'(glog[i]), 64'(i % 2));

      // timeout, then a normal read re-requested straight through done0
      q0.push_back(mk(1'b0, 10'h155, 32'h0, TIMEOUT + 4, 32'h1111_1111));
      q0.push_back(mk(1'b0, 10'h156, 32'h0, 1, 32'h2222_2222));
      run_until_idle(100);

      // asynchronous reset in the middle of ACCESS
      q0.push_back(mk(1'b1, 10'h0AA, 32'h0BAD_F00D, 10, 32'h0));
      tick();
      q1.push_back(mk(1'b0, 10'h1BB, 32'h0, 0, 32'h3333_3333));
      repeat (4) tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_cycle();
      repeat (3) tick();
      glog.delete();
      reset = 1'b1;
      drive_sched();
      run_until_idle(100);
      check_eq("post_reset_grants", 64'(glog.size()), 64'd2);
      if (glog.size() > 0) check_eq("post_reset_tie", 64'(glog[0]), 64'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if (q0.size() == 0 && ($urandom % 3 == 0)) q0.push_back(rand_cmd());
         if (q1.size() == 0 && ($urandom % 3 == 0)) q1.push_back(rand_cmd());
         tick();
      end
      run_until_idle(200);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that shares the single APB slave (request = select & enable, completion = ready) between two local requesters.
- Round-robin arbitration; the APB transfer is driven through SETUP and ACCESS phases.
- Each transfer completes with a one-cycle done pulse, read data on reads, and an error flag on timeout.
- Sits between local command sources (e.g. test sequencers or DMA) and the slave interface.

Parameters:
ADDR_W, 10, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles without ready before abort; 0 disables the timeout

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 command valid; held until done0
write0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
rdata0  output  DATA_W  requester 0 read data, valid when done0 is high and err0 is low
done0  output  1  one-cycle completion pulse to requester 0
err0  output  1  timeout flag, qualified by done0
req1/write1/addr1/wdata1/rdata1/done1/err1  same widths/meaning  requester 1
select  output  1  APB PSEL to slave
enable  output  1  APB PENABLE to slave
ADDR  output  ADDR_W  APB address
WRITE  output  1  APB write strobe
WDATA  output  DATA_W  APB write data
RDATA  input  DATA_W  APB read data from slave
ready_i  input  1  APB ready from slave
busy_o  output  1  high while state is not IDLE
gnt_o  output  1  index of the current/last granted requester

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0.
  - Internal last_grant=1, so requester 0 wins the first tie.
  - Wait counter=0.
  - Reset asserted mid-transfer aborts immediately; no done pulse is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: select=0, enable=0.
  - Effective request = reqN & ~doneN. This masks a requester in the cycle its done pulse is high.
  - If either effective request is high, grant at the clock edge:
    - Only one high: that requester wins.
    - Both high: the requester != last_grant wins.
  - On grant: latch its write/addr/wdata into WRITE/ADDR/WDATA; last_grant and gnt_o = winner; go to SETUP.
  - With no request: ADDR/WRITE/WDATA hold their previous values.
- SETUP: select=1, enable=0 for exactly one cycle; then go to ACCESS.
- ACCESS: select=1, enable=1.
  - If ready_i=1:
    - Read transfers: RDATA is registered into rdataN of the granted requester. The other requester's rdata is unchanged. Write transfers leave rdataN unchanged.
    - doneN pulses in the next cycle with errN=0.
    - Wait counter clears; go to IDLE.
  - Else the wait counter increments.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ready: doneN pulses with errN=1, rdataN is unchanged, go to IDLE.
- done/err are registered and are high only in the first IDLE cycle after completion. errN is 0 whenever doneN is 0.
- Latency: a request seen in IDLE at cycle 0 gives SETUP at 1 and ACCESS at 2. Zero-wait ready then gives done at 3. Minimum throughput is one transfer per 3 cycles.
- ADDR, WRITE and WDATA are stable from SETUP through the final ACCESS cycle. Requester inputs changing mid-transfer are ignored.
- A requester dropping req mid-transfer is ignored; the transfer completes and still pulses done.
- Continuous requests from both requesters: grants strictly alternate 0,1,0,1.
- busy_o = (state != IDLE).

Test Plan:
- Single write: req0, addr0=0x012, wdata0=0xDEADBEEF, ready_i tied 1 → SETUP/ACCESS seen on cycles 1/2 with ADDR=0x012, WRITE=1; done0 at cycle 3; err0=0.
- Read with 2 wait states: req1 read at addr 0x3FF, ready_i high on the 3rd ACCESS cycle, RDATA=0xA5A5_0001 → rdata1=0xA5A5_0001 with done1; enable stays high for 3 cycles; rdata0 is unchanged.
- Contention: req0 and req1 both held for 4 transfers → grant order 0,1,0,1; exactly one IDLE cycle between transfers; gnt_o matches.
- Timeout: TIMEOUT=16, ready_i held 0 → ACCESS lasts 16 cycles, then done0=1 and err0=1; rdata0 is unchanged; the next transfer then succeeds normally.
- Reset mid-ACCESS: reset=0 during a pending transfer → select, enable and busy_o drop asynchronously, with no done pulse. After release, a tie is won by requester 0.
- Request masking: req0 kept high through done0 with req1 low → a second transfer for requester 0 starts only on the cycle after done0, never twice within the done cycle.
